memory_stage: RTL and testbench



---
 rtl/memory_stage.sv | 98 +++++++++
 tb/tb_memory_stage.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: LEGv8 MEM pipeline stage with EX/MEM register, req/ack wait-state FSM, timeout abort and branch resolution.
module memory_stage #(
  parameter int N = 64,
  parameter int MAX_WAIT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic         MemRead_E,
  input  logic         MemWrite_E,
  input  logic         Branch_E,
  input  logic         zero_E,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  input  logic [N-1:0] PCBranch_E,
  output logic         stall_M,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [N-1:0] mem_rdata,
  output logic         valid_M,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] readData_M,
  output logic [N-1:0] PCBranch_M,
  output logic         PCSrc_M,
  output logic         mem_err
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_next;
  logic r_we, r_taken;
  logic [N-1:0] r_addr, r_wdata, r_pcb;
  logic [7:0] cnt;
  logic is_mem, aligned, busy, timeout, done;
  assign is_mem  = valid_E & (MemRead_E | MemWrite_E);
  assign aligned = aluResult_E[2:0] == 3'b000;
  assign busy    = state == BUSY;
  assign timeout = cnt == 8'(MAX_WAIT - 1);
  assign done    = busy & (mem_ack | timeout);
  assign stall_M   = busy;
  assign mem_req   = busy;
  assign mem_we    = busy & r_we;
  assign mem_addr  = busy ? r_addr : '0;
  assign mem_wdata = busy ? r_wdata : '0;
  always_comb begin
    state_next = state;
    state_next = busy ? (done ? IDLE : BUSY) : ((is_mem & aligned) ? BUSY : IDLE);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we        <= 1'b0;
      r_taken     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_pcb       <= '0;
      cnt         <= '0;
      valid_M     <= 1'b0;
      aluResult_M <= '0;
      readData_M  <= '0;
      PCBranch_M  <= '0;
      PCSrc_M     <= 1'b0;
      mem_err     <= 1'b0;
    end else begin
      valid_M <= 1'b0;
      PCSrc_M <= 1'b0;
      if (!busy) begin
        r_we    <= MemWrite_E;
        r_taken <= Branch_E & zero_E;
        r_addr  <= aluResult_E;
        r_wdata <= writeData_E;
        r_pcb   <= PCBranch_E;
        cnt     <= '0;
        if (valid_E && !(is_mem && aligned)) begin
          valid_M     <= 1'b1;
          aluResult_M <= aluResult_E;
          PCBranch_M  <= PCBranch_E;
          PCSrc_M     <= Branch_E & zero_E;
          readData_M  <= '0;
          if (is_mem) mem_err <= 1'b1;
        end
      end else if (done) begin
        // ack wins over a timeout landing on the same edge
        valid_M     <= 1'b1;
        aluResult_M <= r_addr;
        PCBranch_M  <= r_pcb;
        PCSrc_M     <= r_taken;
        readData_M  <= (mem_ack && !r_we) ? mem_rdata : '0;
        if (!mem_ack) mem_err <= 1'b1;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed plan steps plus random ops checked against a per-instruction outcome model.
module tb_memory_stage;
  localparam int N = 64;
  localparam int MAX_WAIT = 15;
  logic clk = 0, reset = 1;
  logic valid_E = 0, MemRead_E = 0, MemWrite_E = 0, Branch_E = 0, zero_E = 0;
  logic [N-1:0] aluResult_E = '0, writeData_E = '0, PCBranch_E = '0, mem_rdata = '0;
  logic mem_ack = 0;
  logic stall_M, mem_req, mem_we, valid_M, PCSrc_M, mem_err;
  logic [N-1:0] mem_addr, mem_wdata, aluResult_M, readData_M, PCBranch_M;
  int total = 0, bad = 0;
  logic [N-1:0] exp_alu = '0, exp_pcb = '0, exp_rd = '0;
  logic exp_v = 0, exp_pcsrc = 0, exp_err = 0;

  memory_stage #(.N(N), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .valid_E(valid_E), .MemRead_E(MemRead_E), .MemWrite_E(MemWrite_E),
    .Branch_E(Branch_E), .zero_E(zero_E), .aluResult_E(aluResult_E), .writeData_E(writeData_E),
    .PCBranch_E(PCBranch_E), .stall_M(stall_M), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .valid_M(valid_M), .aluResult_M(aluResult_M), .readData_M(readData_M), .PCBranch_M(PCBranch_M),
    .PCSrc_M(PCSrc_M), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall"}, stall_M, 0);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_valid"}, valid_M, 0);
    chk({tag, "_alu"}, aluResult_M, 0);
    chk({tag, "_rd"}, readData_M, 0);
    chk({tag, "_pcb"}, PCBranch_M, 0);
    chk({tag, "_pcsrc"}, PCSrc_M, 0);
    chk({tag, "_err"}, mem_err, 0);
  endtask

  task automatic drive(input logic v, rd, wr, br, z, input logic [N-1:0] a, wd, pcb);
    valid_E = v; MemRead_E = rd; MemWrite_E = wr; Branch_E = br; zero_E = z;
    aluResult_E = a; writeData_E = wd; PCBranch_E = pcb;
  endtask

  // lat = BUSY cycle in which ack arrives; 0 = never (timeout)
  task automatic do_op(input string tag, input logic v, rd, wr, br, z,
                       input logic [N-1:0] a, wd, pcb, input int lat);
    logic mem, acked;
    logic [N-1:0] rdv;
    mem = v & (rd | wr);
    acked = 0;
    rdv = '0;
    drive(v, rd, wr, br, z, a, wd, pcb);
    mem_ack = 1'($urandom);
    mem_rdata = {$urandom, $urandom};
    tick();
    mem_ack = 0;
    if (mem && a[2:0] == 3'b000) begin
      for (int c = 1; c <= MAX_WAIT; c++) begin
        chk({tag, "_busy_stall"}, stall_M, 1);
        chk({tag, "_busy_req"}, mem_req, 1);
        chk({tag, "_busy_we"}, mem_we, wr);
        chk({tag, "_busy_addr"}, mem_addr, a);
        chk({tag, "_busy_wdata"}, mem_wdata, wd);
        chk({tag, "_busy_valid"}, valid_M, 0);
        chk({tag, "_busy_pcsrc"}, PCSrc_M, 0);
        rdv = {$urandom, $urandom};
        mem_ack = (c == lat);
        mem_rdata = rdv;
        tick();
        mem_ack = 0;
        if (c == lat) begin
          acked = 1;
          break;
        end
      end
      exp_v = 1; exp_alu = a; exp_pcb = pcb; exp_pcsrc = br & z;
      exp_rd = (acked && !wr) ? rdv : '0;
      if (!acked) exp_err = 1;
    end else if (v) begin
      exp_v = 1; exp_alu = a; exp_pcb = pcb; exp_pcsrc = br & z; exp_rd = '0;
      if (mem) exp_err = 1;
    end else begin
      exp_v = 0; exp_pcsrc = 0;
    end
    chk({tag, "_valid"}, valid_M, exp_v);
    chk({tag, "_pcsrc"}, PCSrc_M, exp_pcsrc);
    chk({tag, "_alu"}, aluResult_M, exp_alu);
    chk({tag, "_pcb"}, PCBranch_M, exp_pcb);
    chk({tag, "_rd"}, readData_M, exp_rd);
    chk({tag, "_err"}, mem_err, exp_err);
    chk({tag, "_stall"}, stall_M, 0);
    chk({tag, "_req"}, mem_req, 0);
  endtask

  initial begin
    tick();
    tick();
    chk_zero("reset");
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      do_op("bubble", 0, 0, 0, 0, 0, '0, '0, '0, 0);
      chk_zero("bubble_zero");
    end
    do_op("branch", 1, 0, 0, 1, 1, 64'h10, '0, 64'h40, 0);
    do_op("load_lat3", 1, 1, 0, 0, 0, 64'h18, '0, '0, 3);
    do_op("store_lat1", 1, 0, 1, 0, 0, 64'h20, 64'h55, '0, 1);
    do_op("both_rw", 1, 1, 1, 0, 0, 64'h28, 64'h77, '0, 2);
    do_op("misaligned", 1, 1, 0, 0, 0, 64'h21, '0, '0, 0);
    do_op("clean_after_err", 1, 0, 0, 0, 1, 64'h30, '0, 64'h8, 0);
    do_op("load_lat1_err_sticky", 1, 1, 0, 0, 0, 64'h38, '0, '0, 1);
    do_op("ack_last", 1, 1, 0, 0, 0, 64'h48, '0, '0, MAX_WAIT);
    reset = 1;
    #1;
    reset = 0;
    exp_v = 0; exp_pcsrc = 0; exp_err = 0; exp_alu = '0; exp_pcb = '0; exp_rd = '0;
    do_op("timeout", 1, 1, 0, 0, 0, 64'h8, '0, '0, 0);
    // reset lands mid-cycle during the 5th BUSY cycle
    drive(1, 1, 0, 0, 0, 64'h8, '0, '0);
    tick();
    for (int c = 1; c < 5; c++) tick();
    chk("pre_reset_req", mem_req, 1);
    #2;
    reset = 1;
    #1;
    chk_zero("mid_busy_reset");
    drive(0, 0, 0, 0, 0, '0, '0, '0);
    tick();
    reset = 0;
    exp_v = 0; exp_pcsrc = 0; exp_err = 0; exp_alu = '0; exp_pcb = '0; exp_rd = '0;
    chk_zero("post_reset");
    for (int i = 0; i < 150; i++) begin
      logic [N-1:0] a;
      int k, lat;
      k = $urandom_range(0, 9);
      a = {$urandom, $urandom};
      a[2:0] = (k < 7) ? 3'b000 : 3'($urandom);
      lat = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, MAX_WAIT);
      do_op("rand", 1'(k != 0), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            a, {$urandom, $urandom}, {$urandom, $urandom}, lat);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
